// File: rtl/mem_port_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arb_pkg
// Shared definitions for the unified-SRAM port arbiter:
//   - owner tags carried down the read-return pipe (NONE / I / D / X)
//   - arbiter FSM state encoding
//   - width of the fetch starvation counter
//   - small helper that turns a grant plus byte enables into an owner tag
// No ports (package only).
// ----------------------------------------------------------------------------
package mem_port_arb_pkg;

  localparam int STARVE_W = 4;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_X    = 2'd3;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_FAVOR_I = 1'b1
  } arb_state_e;

  // A granted access only earns a return slot when it is a read (no byte
  // enables set); writes travel down the pipe as NONE.
  function automatic logic [1:0] read_owner(input logic       gnt,
                                            input logic [3:0] we,
                                            input logic [1:0] owner);
    return (gnt && (we == 4'b0000)) ? owner : OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_port_arb_tag_pipe.sv
// ----------------------------------------------------------------------------
// mem_port_arb_tag_pipe
// DEPTH-deep shift register of 2-bit owner tags. A tag enters the cycle an
// access is granted and leaves DEPTH cycles later, lined up with the SRAM
// read data for that access.
// Ports:
//   clk      clock
//   clear    synchronous clear, flushes every stage to OWN_NONE
//   tag_in   owner tag of the access granted this cycle
//   tag_out  owner tag of the access whose data is on the SRAM bus now
// ----------------------------------------------------------------------------
module mem_port_arb_tag_pipe
  import mem_port_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] tag_in,
  output logic [1:0] tag_out
);

  logic [1:0] stage [DEPTH];

  // Clearing every stage is what kills reads that were in flight when the
  // clear hit, so they can never surface as a late rvalid.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= OWN_NONE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous SRAM between the instruction-fetch port
// (i_*) and the MEM-stage data port (d_*). At most one access is granted per
// cycle; read data is steered back to its owner RD_LAT cycles later. Data
// normally has priority, but a fetch denied STARVE_LIMIT cycles in a row is
// forced to win the next cycle.
//
// Optional build macro MEM_PORT_ARB_DMA_EN adds a lowest-priority preload
// port (x_*) that is granted only when neither i nor d requests.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req/i_addr                  fetch request (read only)
//   i_gnt/i_rvalid/i_rdata        fetch grant and read return
//   d_req/d_addr/d_we/d_wdata     data request (d_we == 0 means read)
//   d_gnt/d_rvalid/d_rdata        data grant and load return
//   mem_en/mem_addr/mem_we/
//   mem_wdata/mem_rdata           SRAM macro interface
//   x_* (MEM_PORT_ARB_DMA_EN)     preload port, same shape as d_*
// ----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,

  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,

  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef MEM_PORT_ARB_DMA_EN
  ,
  input  logic              x_req,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [3:0]        x_we,
  input  logic [31:0]       x_wdata,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [31:0]       x_rdata
`endif
);

  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX  = '1;

  arb_state_e          state, state_next;
  logic [STARVE_W-1:0] starve_cnt, starve_cnt_next;
  logic                starve_inc;

  logic                x_req_w;
  logic [ADDR_W-1:0]   x_addr_w;
  logic [3:0]          x_we_w;
  logic [31:0]         x_wdata_w;
  logic                x_gnt_w;

  logic [1:0]          tag_in, tag_out;

  // The preload port is folded into the arbitration through these internal
  // copies; in the two-way build they are tied off and the x branch of the
  // priority chain collapses away.
`ifdef MEM_PORT_ARB_DMA_EN
  assign x_req_w   = x_req;
  assign x_addr_w  = x_addr;
  assign x_we_w    = x_we;
  assign x_wdata_w = x_wdata;
  assign x_gnt     = x_gnt_w;
`else
  assign x_req_w   = 1'b0;
  assign x_addr_w  = '0;
  assign x_we_w    = '0;
  assign x_wdata_w = '0;
`endif

  // Arbiter state and starvation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Grant decision and next-state logic. Everything is held off during reset
  // so nothing reaches the SRAM or the core while rst is high. In FAVOR_I the
  // fetch wins if it asks; the state always falls back to NORMAL after one
  // cycle because fetch is either granted or has stopped requesting.
  always_comb begin
    i_gnt           = 1'b0;
    d_gnt           = 1'b0;
    x_gnt_w         = 1'b0;
    state_next      = state;
    starve_inc      = 1'b0;
    starve_cnt_next = '0;

    if (!rst) begin
      if (state == ST_FAVOR_I && i_req) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end else if (x_req_w) begin
        x_gnt_w = 1'b1;
      end

      starve_inc = i_req && !i_gnt;
      if (starve_inc && starve_cnt != STARVE_MAX) begin
        starve_cnt_next = starve_cnt + 1'b1;
      end else if (starve_inc) begin
        starve_cnt_next = starve_cnt;
      end

      case (state)
        ST_NORMAL: begin
          if (starve_inc && starve_cnt == STARVE_LAST) begin
            state_next = ST_FAVOR_I;
          end
        end
        ST_FAVOR_I: begin
          if (i_gnt || !i_req) begin
            state_next = ST_NORMAL;
          end
        end
        default: state_next = ST_NORMAL;
      endcase
    end
  end

  // SRAM request mux: drive the winner's command, or all zeros when idle.
  // Fetch is read-only so its write enables and data are forced to zero.
  always_comb begin
    mem_addr  = '0;
    mem_we    = '0;
    mem_wdata = '0;
    if (i_gnt) begin
      mem_addr  = i_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_wdata = d_wdata;
    end else if (x_gnt_w) begin
      mem_addr  = x_addr_w;
      mem_we    = x_we_w;
      mem_wdata = x_wdata_w;
    end
  end

  assign mem_en = i_gnt | d_gnt | x_gnt_w;

  // Owner tag of this cycle's access; writes enter the pipe as NONE so they
  // never produce an rvalid.
  always_comb begin
    tag_in = OWN_NONE;
    if (i_gnt) begin
      tag_in = OWN_I;
    end else if (d_gnt) begin
      tag_in = read_owner(d_gnt, d_we, OWN_D);
    end else if (x_gnt_w) begin
      tag_in = read_owner(x_gnt_w, x_we_w, OWN_X);
    end
  end

  mem_port_arb_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .clear   (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Return steering. rdata is zeroed whenever its rvalid is low so a stale
  // SRAM word never leaks to a port that did not ask for it.
  assign i_rvalid = !rst && (tag_out == OWN_I);
  assign d_rvalid = !rst && (tag_out == OWN_D);
  assign i_rdata  = i_rvalid ? mem_rdata : 32'h0;
  assign d_rdata  = d_rvalid ? mem_rdata : 32'h0;

`ifdef MEM_PORT_ARB_DMA_EN
  assign x_rvalid = !rst && (tag_out == OWN_X);
  assign x_rdata  = x_rvalid ? mem_rdata : 32'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives two arbiters (RD_LAT = 1 and RD_LAT = 2) with identical stimulus,
// backed by one behavioural SRAM that feeds each its read data at the right
// latency, and compares both against a cycle-level reference model.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;
  localparam logic [1:0] M_NONE = 2'd0, M_I = 2'd1, M_D = 2'd2, M_X = 2'd3;
`ifdef MEM_PORT_ARB_DMA_EN
  localparam bit DMA = 1'b1;
`else
  localparam bit DMA = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_wdata = '0;
  logic        x_req = 1'b0;
  logic [31:0] x_addr = '0;
  logic [3:0]  x_we = '0;
  logic [31:0] x_wdata = '0;

  logic [1:0]  i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en;
  logic [31:0] i_rdata [2];
  logic [31:0] d_rdata [2];
  logic [31:0] mem_addr [2];
  logic [3:0]  mem_we [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
`ifdef MEM_PORT_ARB_DMA_EN
  logic [1:0]  x_gnt, x_rvalid;
  logic [31:0] x_rdata [2];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W       (32),
      .RD_LAT       (g + 1),
      .STARVE_LIMIT (LIMIT)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_gnt     (i_gnt[g]),
      .i_rvalid  (i_rvalid[g]),
      .i_rdata   (i_rdata[g]),
      .d_req     (d_req),
      .d_addr    (d_addr),
      .d_we      (d_we),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt[g]),
      .d_rvalid  (d_rvalid[g]),
      .d_rdata   (d_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_addr  (mem_addr[g]),
      .mem_we    (mem_we[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
`ifdef MEM_PORT_ARB_DMA_EN
      ,
      .x_req     (x_req),
      .x_addr    (x_addr),
      .x_we      (x_we),
      .x_wdata   (x_wdata),
      .x_gnt     (x_gnt[g]),
      .x_rvalid  (x_rvalid[g]),
      .x_rdata   (x_rdata[g])
`endif
    );
  end

  // Behavioural SRAM (256 words) driven by the RD_LAT=1 arbiter's command;
  // the RD_LAT=2 arbiter sees the same word one cycle later. Non-read
  // cycles put junk on the bus so unmasked rdata would show up.
  logic [31:0] sram [256];
  logic [31:0] ref_mem [256];
  logic [31:0] rq0, rq1;
  logic        preload = 1'b1;

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) sram[k] <= ref_mem[k];
    end else if (mem_en[0] && mem_we[0] != 4'b0) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[0][b]) sram[mem_addr[0][9:2]][8*b +: 8] <= mem_wdata[0][8*b +: 8];
    end
    rq0 <= (mem_en[0] && mem_we[0] == 4'b0) ? sram[mem_addr[0][9:2]] : 32'hDEADBEEF;
    rq1 <= rq0;
  end
  assign mem_rdata[0] = rq0;
  assign mem_rdata[1] = rq1;

  // Reference model state: consecutive fetch-denial count and the owners /
  // data of reads returning 1 and 2 cycles from now.
  int          n_cmp = 0, n_bad = 0;
  int          run = 0;
  logic [1:0]  p_own [2];
  logic [31:0] p_dat [2];
  logic        e_ig, e_dg, e_xg, e_men;
  logic [31:0] e_maddr, e_mwd;
  logic [3:0]  e_mwe;
  logic [1:0]  e_irv, e_drv, e_xrv;
  logic [31:0] e_ird [2];
  logic [31:0] e_drd [2];
  logic [31:0] e_xrd [2];

  // Drive one cycle of inputs at the falling edge, compute what every output
  // must be this cycle, then advance the model past the next rising edge.
  task automatic drive_cycle(input logic rs, input logic ir, input logic [31:0] ia,
                             input logic dr, input logic [31:0] da,
                             input logic [3:0] dwe, input logic [31:0] dwd);
    logic [1:0]  o, nt;
    logic [31:0] nd;
    @(negedge clk);
    rst = rs; i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_we = dwe; d_wdata = dwd;
    #1;
    e_ig = !rs && ir && (!dr || run >= LIMIT);
    e_dg = !rs && dr && !e_ig;
    e_xg = DMA && !rs && x_req && !ir && !dr;
    e_men = e_ig | e_dg | e_xg;
    e_maddr = '0; e_mwe = '0; e_mwd = '0;
    if (e_ig) e_maddr = ia;
    else if (e_dg) begin e_maddr = da; e_mwe = dwe; e_mwd = dwd; end
    else if (e_xg) begin e_maddr = x_addr; e_mwe = x_we; e_mwd = x_wdata; end
    for (int k = 0; k < 2; k++) begin
      o = rs ? M_NONE : p_own[k];
      e_irv[k] = (o == M_I); e_ird[k] = e_irv[k] ? p_dat[k] : 32'h0;
      e_drv[k] = (o == M_D); e_drd[k] = e_drv[k] ? p_dat[k] : 32'h0;
      e_xrv[k] = (o == M_X); e_xrd[k] = e_xrv[k] ? p_dat[k] : 32'h0;
    end
    if (rs) begin
      p_own[0] = M_NONE; p_own[1] = M_NONE; run = 0;
    end else begin
      nt = M_NONE; nd = '0;
      if (e_men) nd = ref_mem[e_maddr[9:2]];
      if (e_ig) nt = M_I;
      else if (e_dg && dwe == 4'b0) nt = M_D;
      else if (e_xg && x_we == 4'b0) nt = M_X;
      for (int b = 0; b < 4; b++)
        if (e_men && e_mwe[b]) ref_mem[e_maddr[9:2]][8*b +: 8] = e_mwd[8*b +: 8];
      p_own[1] = p_own[0]; p_dat[1] = p_dat[0];
      p_own[0] = nt;       p_dat[0] = nd;
      run = (ir && !e_ig) ? run + 1 : 0;
    end
  endtask

  // Reset mid-read: outputs all zero under reset and the killed read never returns.
  task automatic test_reset();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0, 1:    drive_cycle(1, 1, 32'h100, 1, 32'h40, 4'h0, 32'h0);
        2:       drive_cycle(0, 0, 32'h0, 1, 32'h40, 4'h0, 32'h0);
        3, 4:    drive_cycle(1, 1, 32'h104, 1, 32'h44, 4'hF, 32'h1);
        default: drive_cycle(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
      endcase
      if (c == 1) preload = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (c < 2 || c == 3 || c == 4) begin
          n_cmp++;
          if ({i_gnt[k], d_gnt[k], mem_en[k], i_rvalid[k], d_rvalid[k], mem_addr[k], mem_we[k],
               mem_wdata[k], i_rdata[k], d_rdata[k]} !== '0)
            begin n_bad++; $display("[TB] FAIL reset_outputs dut%0d c%0d: got gnt=%b%b en=%b rv=%b%b addr=%h we=%h wd=%h ird=%h drd=%h, want all 0",
              k, c, i_gnt[k], d_gnt[k], mem_en[k], i_rvalid[k], d_rvalid[k], mem_addr[k], mem_we[k], mem_wdata[k], i_rdata[k], d_rdata[k]); end
        end
        if (c == 2) begin
          n_cmp++;
          if ({d_gnt[k], mem_addr[k]} !== {1'b1, 32'h40})
            begin n_bad++; $display("[TB] FAIL reset_d_grant dut%0d: got gnt=%b addr=%h want 1/00000040", k, d_gnt[k], mem_addr[k]); end
        end
        n_cmp++;
        if (c >= 3 && (d_rvalid[k] !== 1'b0 || d_rvalid[k] !== e_drv[k]))
          begin n_bad++; $display("[TB] FAIL reset_no_rvalid dut%0d c%0d: got d_rvalid=%b want 0", k, c, d_rvalid[k]); end
      end
    end
  endtask

  // Single fetch to 0x100 returns the preloaded instruction word.
  task automatic test_solo_fetch();
    for (int c = 0; c < 3; c++) begin
      drive_cycle(0, c == 0, 32'h100, 0, 32'h0, 4'h0, 32'h0);
      n_cmp++;
      if ({i_gnt[0], mem_en[0]} !== {c == 0, c == 0} || i_gnt[0] !== e_ig)
        begin n_bad++; $display("[TB] FAIL fetch_gnt c%0d: got gnt=%b en=%b want %b", c, i_gnt[0], mem_en[0], c == 0); end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({i_rvalid[k], i_rdata[k]} !== ((c == k + 1) ? {1'b1, 32'h00500093} : 33'h0))
          begin n_bad++; $display("[TB] FAIL fetch_return dut%0d c%0d: got rv=%b rd=%h want rv=%b rd=00500093", k, c, i_rvalid[k], i_rdata[k], c == k + 1); end
      end
    end
  endtask

  // Both ports held: four data grants, then the starved fetch, repeating.
  task automatic test_contention();
    logic [9:0] pat;
    pat = 10'b10000_10000;
    for (int c = 0; c < 11; c++) begin
      drive_cycle(0, c < 10, 32'h200, c < 10, 32'($urandom_range(0, 255)) << 2, 4'h0, 32'h0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (c < 10 && ({i_gnt[k], d_gnt[k]} !== {pat[c], !pat[c]} || i_gnt[k] !== e_ig))
          begin n_bad++; $display("[TB] FAIL contention_gnt dut%0d c%0d: got i=%b d=%b want i=%b d=%b", k, c, i_gnt[k], d_gnt[k], pat[c], !pat[c]); end
        n_cmp++;
        if ({i_rvalid[k], i_rdata[k], d_rvalid[k], d_rdata[k]} !== {e_irv[k], e_ird[k], e_drv[k], e_drd[k]})
          begin n_bad++; $display("[TB] FAIL contention_ret dut%0d c%0d: got i=%b/%h d=%b/%h want i=%b/%h d=%b/%h", k, c,
            i_rvalid[k], i_rdata[k], d_rvalid[k], d_rdata[k], e_irv[k], e_ird[k], e_drv[k], e_drd[k]); end
      end
    end
  endtask

  // Half-word store to 0x80, then a load of the same word.
  task automatic test_store_load();
    logic [31:0] want;
    want = {ref_mem[32][31:16], 16'h1234};
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive_cycle(0, 0, 32'h0, 1, 32'h80, 4'b0011, 32'hAAAA1234);
      else        drive_cycle(0, 0, 32'h0, c == 1, 32'h80, 4'h0, 32'h0);
      if (c == 0) begin
        n_cmp++;
        if ({d_gnt[0], mem_addr[0], mem_we[0], mem_wdata[0]} !== {1'b1, 32'h80, 4'b0011, 32'hAAAA1234})
          begin n_bad++; $display("[TB] FAIL store_cmd: got gnt=%b a=%h we=%b wd=%h want 1/80/0011/aaaa1234", d_gnt[0], mem_addr[0], mem_we[0], mem_wdata[0]); end
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({d_rvalid[k], d_rdata[k]} !== ((c == k + 2) ? {1'b1, want} : 33'h0) || d_rvalid[k] !== e_drv[k])
          begin n_bad++; $display("[TB] FAIL store_load dut%0d c%0d: got rv=%b rd=%h want rv=%b rd=%h", k, c, d_rvalid[k], d_rdata[k], c == k + 2, want); end
      end
    end
  endtask

  // Consecutive d/i/d reads; RD_LAT=2 returns them on cycles 2, 3, 4.
  task automatic test_back_to_back();
    logic [31:0] w10, w20, w30;
    w10 = ref_mem[4]; w20 = ref_mem[8]; w30 = ref_mem[12];
    for (int c = 0; c < 5; c++) begin
      drive_cycle(0, c == 1, 32'h20, c == 0 || c == 2, (c == 0) ? 32'h10 : 32'h30, 4'h0, 32'h0);
      n_cmp++;
      if ({d_rvalid[1], d_rdata[1]} !== ((c == 2) ? {1'b1, w10} : (c == 4) ? {1'b1, w30} : 33'h0))
        begin n_bad++; $display("[TB] FAIL b2b_d_lat2 c%0d: got rv=%b rd=%h", c, d_rvalid[1], d_rdata[1]); end
      n_cmp++;
      if ({i_rvalid[1], i_rdata[1]} !== ((c == 3) ? {1'b1, w20} : 33'h0))
        begin n_bad++; $display("[TB] FAIL b2b_i_lat2 c%0d: got rv=%b rd=%h want rv=%b rd=%h", c, i_rvalid[1], i_rdata[1], c == 3, w20); end
      n_cmp++;
      if ({i_rvalid[0], i_rdata[0], d_rvalid[0], d_rdata[0]} !== {e_irv[0], e_ird[0], e_drv[0], e_drd[0]})
        begin n_bad++; $display("[TB] FAIL b2b_lat1 c%0d: got i=%b/%h d=%b/%h want i=%b/%h d=%b/%h", c,
          i_rvalid[0], i_rdata[0], d_rvalid[0], d_rdata[0], e_irv[0], e_ird[0], e_drv[0], e_drd[0]); end
    end
  endtask

  // Random traffic with occasional reset, misaligned fetches and byte stores.
  task automatic test_random();
    logic [3:0] we;
    for (int c = 0; c < 300; c++) begin
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (DMA) begin
        x_req = ($urandom_range(0, 2) == 0); x_addr = 32'($urandom_range(0, 1023));
        x_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hF; x_wdata = $urandom;
      end
      drive_cycle($urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0, 32'($urandom_range(0, 1023)),
                  $urandom_range(0, 2) != 0, 32'($urandom_range(0, 1023)), we, $urandom);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({i_gnt[k], d_gnt[k], mem_en[k], mem_addr[k], mem_we[k], mem_wdata[k]} !== {e_ig, e_dg, e_men, e_maddr, e_mwe, e_mwd})
          begin n_bad++; $display("[TB] FAIL rand_cmd dut%0d c%0d: got %b%b%b %h %h %h want %b%b%b %h %h %h", k, c,
            i_gnt[k], d_gnt[k], mem_en[k], mem_addr[k], mem_we[k], mem_wdata[k], e_ig, e_dg, e_men, e_maddr, e_mwe, e_mwd); end
        n_cmp++;
        if ({i_rvalid[k], i_rdata[k], d_rvalid[k], d_rdata[k]} !== {e_irv[k], e_ird[k], e_drv[k], e_drd[k]})
          begin n_bad++; $display("[TB] FAIL rand_ret dut%0d c%0d: got i=%b/%h d=%b/%h want i=%b/%h d=%b/%h", k, c,
            i_rvalid[k], i_rdata[k], d_rvalid[k], d_rdata[k], e_irv[k], e_ird[k], e_drv[k], e_drd[k]); end
`ifdef MEM_PORT_ARB_DMA_EN
        n_cmp++;
        if ({x_gnt[k], x_rvalid[k], x_rdata[k]} !== {e_xg, e_xrv[k], e_xrd[k]})
          begin n_bad++; $display("[TB] FAIL rand_x dut%0d c%0d: got %b %b/%h want %b %b/%h", k, c,
            x_gnt[k], x_rvalid[k], x_rdata[k], e_xg, e_xrv[k], e_xrd[k]); end
`endif
      end
    end
    x_req = 1'b0;
    drive_cycle(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    drive_cycle(0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
  endtask

`ifdef MEM_PORT_ARB_DMA_EN
  // Preload port runs while i/d idle and is preempted the cycle d asks.
  task automatic test_dma();
    x_req = 1'b1; x_addr = 32'h44; x_we = 4'h0; x_wdata = '0;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) x_req = 1'b0;
      drive_cycle(0, 0, 32'h0, c == 3, 32'h48, 4'h0, 32'h0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({x_gnt[k], d_gnt[k]} !== {c < 3, c == 3})
          begin n_bad++; $display("[TB] FAIL dma_gnt dut%0d c%0d: got x=%b d=%b want x=%b d=%b", k, c, x_gnt[k], d_gnt[k], c < 3, c == 3); end
        n_cmp++;
        if ({x_rvalid[k], x_rdata[k], d_rvalid[k], d_rdata[k]} !== {e_xrv[k], e_xrd[k], e_drv[k], e_drd[k]})
          begin n_bad++; $display("[TB] FAIL dma_ret dut%0d c%0d: got x=%b/%h d=%b/%h", k, c, x_rvalid[k], x_rdata[k], d_rvalid[k], d_rdata[k]); end
      end
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < 256; k++) ref_mem[k] = $urandom;
    ref_mem[64] = 32'h00500093;
    p_own[0] = M_NONE; p_own[1] = M_NONE; p_dat[0] = '0; p_dat[1] = '0;
    test_reset();
    test_solo_fetch();
    test_contention();
    test_store_load();
    test_back_to_back();
`ifdef MEM_PORT_ARB_DMA_EN
    test_dma();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data/instruction SRAM between the pipeline's instruction-fetch port and its MEM-stage data port.
- Grants at most one access per cycle and routes read data back to the owner after a fixed SRAM latency.
- Prevents fetch starvation with a bounded-wait counter.
- Sits between the core's fetch/data memory ports and the unified memory macro. Denied grants are used by the core as stall sources.

Parameters:
- ADDR_W, 32, byte-address width on all ports.
- RD_LAT, 1, SRAM read latency in cycles. Legal values are 1 and 2.
- STARVE_LIMIT, 4, consecutive cycles fetch may be denied while requesting before it is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch request (read only)
- i_addr  in  ADDR_W  fetch address (word aligned)
- i_gnt  out  1  fetch granted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  32  fetch data
- d_req  in  1  data request
- d_addr  in  ADDR_W  data address
- d_we  in  4  byte write enables (0 = read)
- d_wdata  in  32  store data, already lane-aligned
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  32  load data
- mem_en  out  1  SRAM access strobe
- mem_addr  out  ADDR_W  SRAM address
- mem_we  out  4  SRAM byte write enables
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, RD_LAT cycles after mem_en

Behaviour:
- Grant timing
  - Grants are combinational from req and FSM state.
  - mem_en = OR of grants.
  - mem_addr, mem_we and mem_wdata are muxed from the granted port. They are 0 when no port is granted.
- FSM states
  - NORMAL: data has priority over fetch.
  - FAVOR_I: fetch has priority.
- Starvation counter (starve_cnt, 4 bits)
  - Increments each cycle with i_req=1 and i_gnt=0.
  - Clears on i_gnt or when i_req=0.
  - NORMAL -> FAVOR_I when starve_cnt reaches STARVE_LIMIT-1 and the increment condition holds.
  - FAVOR_I -> NORMAL after the cycle in which fetch is granted, or if i_req drops.
- Read-return routing
  - Each granted read pushes an owner tag (NONE/I/D) into an RD_LAT-deep tag pipe. Writes push NONE.
  - At the pipe output, tag I asserts i_rvalid for 1 cycle with i_rdata=mem_rdata. Tag D asserts d_rvalid the same way.
  - rvalid is never asserted for a write.
  - Full throughput: one access per cycle, back-to-back mixed owners allowed.
- Simultaneous events
  - Both ports requesting in NORMAL: d wins, i waits.
  - Both requesting in FAVOR_I: i wins.
- Address rules
  - Addresses pass through unmodified.
  - A misaligned i_addr is granted anyway; fetch alignment is the core's responsibility.
- Reset
  - Synchronous, active-high.
  - Forces state to NORMAL, starve_cnt to 0, and all tag-pipe entries to NONE.
  - While rst=1: all gnt, rvalid and mem_en are 0; mem_addr, mem_we and mem_wdata are 0; rdata outputs are 0.
  - A read in flight when reset asserts never produces rvalid, including after reset deasserts.
- rdata outputs are 0 whenever the corresponding rvalid is 0 (no stale data).

Optional Feature:
- Macro: MEM_PORT_ARB_DMA_EN.
- When defined, adds a third lowest-priority port for bench/bootloader preload:
  - Inputs: x_req, x_addr, x_we[3:0], x_wdata.
  - Outputs: x_gnt, x_rvalid, x_rdata.
  - Tag X is added to the tag pipe.
  - x is granted only when neither i nor d requests.
  - x does not participate in the starvation counter.
- When undefined, the ports do not exist and arbitration is strictly two-way.

Decomposition:
- Package mem_port_arb_pkg holds:
  - Owner tag constants OWN_NONE=0, OWN_I=1, OWN_D=2, OWN_X=3 (2-bit).
  - FSM state encodings ST_NORMAL and ST_FAVOR_I.
  - Starve-counter width.
- One natural sub-module, mem_port_arb_tag_pipe: parameterised RD_LAT-deep shift register of owner tags with synchronous clear.

Test Plan:
1. Reset mid-read: d read to 0x40 granted, rst=1 the next cycle for 2 cycles -> no d_rvalid ever, and all outputs are 0 during reset.
2. Solo fetch: i_req=1, i_addr=0x100, SRAM word 0x00500093, RD_LAT=1 -> i_gnt same cycle, i_rvalid=1 with i_rdata=0x00500093 one cycle later.
3. Contention: i_req and d_req both held, STARVE_LIMIT=4 -> d granted 4 consecutive cycles, i granted on the 5th, then d resumes.
4. Store then load: d_we=4'b0011, d_wdata=0xAAAA1234 at 0x80, then a load at 0x80 -> no rvalid for the store; load returns 0x????1234 with the upper half holding its prior value.
5. Back-to-back mixed, RD_LAT=2: grants d(read 0x10), i(0x20), d(0x30) on consecutive cycles -> d_rvalid, i_rvalid, d_rvalid on cycles 2, 3, 4 with the matching data.
6. With MEM_PORT_ARB_DMA_EN: x_req held with i/d idle for 3 cycles, then d_req -> x granted 3 cycles, then d preempts in the same cycle d_req rises.
